qmul_pipe: RTL and testbench

Streaming, parametrised signed fixed-point multiplier for the FM radio datapath. It supersedes the combinational Q-format multiply and dequantize helpers with a 3-stage pipelined block. The block has valid/ready flow control, selectable rounding, saturation and a sticky saturation flag. It sits between any two DSP stages (FIR taps, demodulator gain, volume) that exchange Q-format samples.

---
 rtl/qmul_pipe.sv | 112 +++++++++++
 tb/tb_qmul_pipe.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qmul_pipe.sv
// Three-stage pipelined signed Q-format multiplier with valid/ready flow control and saturation.
// Define QMUL_ROUND_NEAREST_EN for round-half-away-from-zero; the default truncates toward zero.
module qmul_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 10
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sat,
    input  logic                  sat_clr,
    output logic                  sat_sticky
);

    // One extra bit over the full product so the bias add can never wrap.
    localparam int PW = 2 * DATA_WIDTH + 1;

    localparam logic signed [PW-1:0] SAT_MAX =
        PW'({1'b0, {(DATA_WIDTH-1){1'b1}}});
    localparam logic signed [PW-1:0] SAT_MIN =
        {{(PW-DATA_WIDTH){1'b1}}, 1'b1, {(DATA_WIDTH-1){1'b0}}};

`ifdef QMUL_ROUND_NEAREST_EN
    localparam logic signed [PW-1:0] BIAS_POS = PW'(1) << (FRAC_BITS - 1);
    localparam logic signed [PW-1:0] BIAS_NEG = (PW'(1) << (FRAC_BITS - 1)) - PW'(1);
`else
    localparam logic signed [PW-1:0] BIAS_POS = '0;
    localparam logic signed [PW-1:0] BIAS_NEG = (PW'(1) << FRAC_BITS) - PW'(1);
`endif

    logic                    adv;
    logic [DATA_WIDTH-1:0]   a_reg, b_reg;
    logic                    v1_reg;
    logic [2*DATA_WIDTH-1:0] p_reg, p_next;
    logic                    v2_reg;
    logic [DATA_WIDTH-1:0]   out_data_reg, out_data_next;
    logic                    out_sat_reg, out_sat_next;
    logic                    out_valid_reg;
    logic                    sat_sticky_reg;

    logic signed [PW-1:0]    p_ext, bias, sum, q;

    // Single global enable: every stage advances together or holds together.
    assign adv        = !out_valid_reg || out_ready;
    assign in_ready   = adv;
    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign out_sat    = out_sat_reg;
    assign sat_sticky = sat_sticky_reg;

    always_comb begin
        // Low 2W bits of the product are the same for signed and unsigned once sign-extended.
        p_next = {{DATA_WIDTH{a_reg[DATA_WIDTH-1]}}, a_reg}
               * {{DATA_WIDTH{b_reg[DATA_WIDTH-1]}}, b_reg};
    end

    always_comb begin
        p_ext = $signed({p_reg[2*DATA_WIDTH-1], p_reg});
        bias  = p_reg[2*DATA_WIDTH-1] ? BIAS_NEG : BIAS_POS;
        sum   = p_ext + bias;
        q     = sum >>> FRAC_BITS;
        out_data_next = q[DATA_WIDTH-1:0];
        out_sat_next  = 1'b0;
        if (q > SAT_MAX) begin
            out_data_next = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            out_sat_next  = 1'b1;
        end else if (q < SAT_MIN) begin
            out_data_next = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            out_sat_next  = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            a_reg         <= '0;
            b_reg         <= '0;
            v1_reg        <= 1'b0;
            p_reg         <= '0;
            v2_reg        <= 1'b0;
            out_data_reg  <= '0;
            out_sat_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
        end else if (adv) begin
            a_reg         <= in_a;
            b_reg         <= in_b;
            v1_reg        <= in_valid;
            p_reg         <= p_next;
            v2_reg        <= v1_reg;
            out_data_reg  <= out_data_next;
            out_sat_reg   <= out_sat_next;
            out_valid_reg <= v2_reg;
        end
    end

    // A saturated result leaving the block takes priority over a clear in the same cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sat_sticky_reg <= 1'b0;
        end else if (out_valid_reg && out_ready && out_sat_reg) begin
            sat_sticky_reg <= 1'b1;
        end else if (sat_clr) begin
            sat_sticky_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_qmul_pipe.sv
// Scoreboard bench for qmul_pipe at DATA_WIDTH=32, FRAC_BITS=10.
// Expected results come from an integer-division reference model.
module tb_qmul_pipe;

    localparam longint QMAX = 64'sd2147483647;
    localparam longint QMIN = -64'sd2147483648;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a, in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sat;
    logic        sat_clr;
    logic        sat_sticky;

    logic [32:0] exp_q[$];
    logic [32:0] obs_q[$];
    int          checks = 0;
    int          fails  = 0;

    always #5 clock = ~clock;

    qmul_pipe #(.DATA_WIDTH(32), .FRAC_BITS(10)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
        .sat_clr(sat_clr), .sat_sticky(sat_sticky)
    );

    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
        longint p, q;
        p = longint'($signed(a)) * longint'($signed(b));
`ifdef QMUL_ROUND_NEAREST_EN
        if (p >= 0) q = (p + 512) / 1024;
        else        q = -((-p + 512) / 1024);
`else
        q = p / 1024;
`endif
        if (q > QMAX) return {1'b1, 32'h7FFF_FFFF};
        if (q < QMIN) return {1'b1, 32'h8000_0000};
        return {1'b0, q[31:0]};
    endfunction

    // Drive one cycle; record input transfers into the scoreboard and output transfers as observed.
    task automatic cycle(input logic iv, input logic [31:0] a, input logic [31:0] b,
                         input logic ordy, input logic clr, output logic xf);
        @(negedge clock);
        in_valid = iv; in_a = a; in_b = b; out_ready = ordy; sat_clr = clr;
        #1;
        xf = iv && in_ready;
        if (xf) exp_q.push_back(model(a, b));
        if (out_valid && out_ready) obs_q.push_back({out_sat, out_data});
    endtask

    task automatic drain();
        logic xf;
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, xf);
    endtask

    task automatic test_reset();
        logic xf;
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, xf);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_sat !== 1'b0 || sat_sticky !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs got v=%b d=%h s=%b st=%b want 0 0 0 0",
                     out_valid, out_data, out_sat, sat_sticky);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        @(negedge clock); reset_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic xf;
        int   lat;
        logic [32:0] o, e;
        lat = -1;
        cycle(1'b1, 32'd1536, 32'd2048, 1'b1, 1'b0, xf);
        for (int k = 1; k <= 10 && lat < 0; k++) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, xf);
            if (out_valid) begin
                lat = k;
                checks++;
                if (out_data !== 32'd3072 || out_sat !== 1'b0) begin
                    fails++; $display("FAIL basic_value got %0d sat=%b want 3072 sat=0", out_data, out_sat);
                end
            end
        end
        checks++;
        if (lat != 3) begin
            fails++; $display("FAIL basic_latency got %0d want 3", lat);
        end
        drain();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            fails++; $display("FAIL basic_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin fails++; $display("FAIL basic_sb got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        $display("test_basic latency=%0d", lat);
    endtask

    task automatic test_rounding();
        logic xf;
        logic [31:0] ra[3];
        logic [31:0] rq[3];
        logic [32:0] o, e;
        ra[0] = 32'hFFFF_FFFD; ra[1] = 32'hFFFF_FE00; ra[2] = 32'h0000_0200;
`ifdef QMUL_ROUND_NEAREST_EN
        rq[0] = 32'h0; rq[1] = 32'hFFFF_FFFF; rq[2] = 32'h1;
`else
        rq[0] = 32'h0; rq[1] = 32'h0; rq[2] = 32'h0;
`endif
        for (int i = 0; i < 3; i++) cycle(1'b1, ra[i], 32'd1, 1'b1, 1'b0, xf);
        drain();
        checks++;
        if (obs_q.size() != 3) begin
            fails++; $display("FAIL round_count got %0d want 3", obs_q.size());
        end
        for (int i = 0; i < 3 && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (o !== {1'b0, rq[i]}) begin
                fails++; $display("FAIL round_const[%0d] got %h want %h", i, o, {1'b0, rq[i]});
            end
            checks++;
            if (o !== e) begin fails++; $display("FAIL round_sb[%0d] got %h want %h", i, o, e); end
            $display("round a=%h -> %h", ra[i], o[31:0]);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_saturation();
        logic xf, seen;
        logic [32:0] o, e;
        cycle(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0, xf);
        cycle(1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, xf);
        cycle(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, xf);
        drain();
        checks++;
        if (obs_q.size() != 3) begin
            fails++; $display("FAIL sat_count got %0d want 3", obs_q.size());
        end
        if (obs_q.size() > 0) begin
            checks++;
            if (obs_q[0] !== {1'b1, 32'h7FFF_FFFF}) begin
                fails++; $display("FAIL sat_max got %h want 17fffffff", obs_q[0]);
            end
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin fails++; $display("FAIL sat_sb got %h want %h", o, e); end
        end
        checks++;
        if (sat_sticky !== 1'b1) begin fails++; $display("FAIL sat_sticky_set got %b want 1", sat_sticky); end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, xf);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, xf);
        checks++;
        if (sat_sticky !== 1'b0) begin fails++; $display("FAIL sat_sticky_clr got %b want 0", sat_sticky); end
        // Hold sat_clr high right through the cycle the saturated result leaves.
        seen = 1'b0;
        cycle(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b1, xf);
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, xf);
            if (out_valid) seen = 1'b1;
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, xf);
        checks++;
        if (!seen || sat_sticky !== 1'b1) begin
            fails++; $display("FAIL sat_set_wins got seen=%b sticky=%b want 1 1", seen, sat_sticky);
        end
        exp_q.delete(); obs_q.delete();
        $display("test_saturation done");
    endtask

    task automatic test_reset_mid();
        logic xf;
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h7FFF_FFFF, 32'd4096 + i, 1'b1, 1'b0, xf);
        @(negedge clock);
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clock);
        reset_n = 1'b1; #1;
        checks++;
        if (out_valid !== 1'b0 || sat_sticky !== 1'b0) begin
            fails++; $display("FAIL mid_reset got v=%b sticky=%b want 0 0", out_valid, sat_sticky);
        end
        exp_q.delete(); obs_q.delete();
        drain();
        checks++;
        if (obs_q.size() != 0) begin
            fails++; $display("FAIL mid_reset_stale got %0d outputs want 0", obs_q.size());
        end
        exp_q.delete(); obs_q.delete();
        $display("test_reset_mid done");
    endtask

    task automatic test_back_to_back();
        logic xf, prev_stall;
        logic [31:0] prev_data;
        logic [32:0] o, e;
        int   sent, stalls;
        sent = 0; stalls = 0; prev_stall = 1'b0; prev_data = '0;
        for (int c = 0; c < 30; c++) begin
            cycle(sent < 8, 32'(sent * 1024), 32'd1024, !(c >= 4 && c <= 9), 1'b0, xf);
            if (xf) sent++;
            if (out_valid && !out_ready) begin
                stalls++;
                checks++;
                if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready c=%0d got %b want 0", c, in_ready); end
                if (prev_stall) begin
                    checks++;
                    if (out_data !== prev_data) begin
                        fails++; $display("FAIL bp_stable c=%0d got %h want %h", c, out_data, prev_data);
                    end
                end
                prev_stall = 1'b1; prev_data = out_data;
            end else begin
                prev_stall = 1'b0;
            end
        end
        checks++;
        if (stalls != 6 || obs_q.size() != 8) begin
            fails++; $display("FAIL bp_counts got stalls=%0d outs=%0d want 6 8", stalls, obs_q.size());
        end
        for (int k = 0; obs_q.size() > 0 && exp_q.size() > 0; k++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e || o !== {1'b0, 32'(k * 1024)}) begin
                fails++; $display("FAIL bp_order[%0d] got %h want %h", k, o, {1'b0, 32'(k * 1024)});
            end
        end
        exp_q.delete(); obs_q.delete();
        $display("test_back_to_back sent=%0d stalls=%0d", sent, stalls);
    endtask

    task automatic test_random();
        logic xf;
        logic [31:0] a, b;
        logic [32:0] o, e;
        int sent, errs;
        sent = 0; errs = 0;
        for (int c = 0; c < 40000 && sent < 10000; c++) begin
            a = $urandom; b = $urandom;
            if ($urandom_range(0, 1) == 0) a = 32'($signed(a[19:0]));
            if ($urandom_range(0, 1) == 0) b = 32'($signed(b[15:0]));
            cycle($urandom_range(0, 3) != 0, a, b, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, xf);
            if (xf) sent++;
        end
        drain();
        checks++;
        if (sent != 10000 || obs_q.size() != exp_q.size()) begin
            fails++; $display("FAIL rand_count got sent=%0d outs=%0d want 10000 %0d", sent, obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin
                errs++; fails++;
                if (errs <= 10) $display("FAIL rand_sb got %h want %h", o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
        $display("test_random sent=%0d errors=%0d", sent, errs);
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0; sat_clr = 1'b0;
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
